// File: rtl/conv_pkg.sv
// Shared helpers for the convolution datapath: width math and saturation.
// Optional feature macro used by conv_mac_array: RELU_EN.
package conv_pkg;

    typedef struct packed {
        logic        flag;
        logic [63:0] val;
    } sat_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int acc_min_width(
        input int dw,
        input int k2,
        input int ic
    );
        return 2 * dw + clog2(k2 * ic) + 1;
    endfunction

    // Clip a wide signed value into the signed range of ow bits.
    function automatic sat_t saturate(
        input logic signed [63:0] v,
        input int                 ow
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sat_t               r;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ow - 1));
        r.flag = 1'b1;
        if (v > hi) begin
            r.val = hi;
        end else if (v < lo) begin
            r.val = lo;
        end else begin
            r.val  = v;
            r.flag = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/adder_tree_pipe.sv
// Registered binary adder tree with a matching valid pipeline.
// Inputs are sign-extended to OUT_W; odd leftovers pass through a register.
module adder_tree_pipe
    import conv_pkg::*;
#(
    parameter int N     = 9,
    parameter int IN_W  = 16,
    parameter int OUT_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [N*IN_W-1:0] in_data,
    output logic              out_valid,
    output logic [OUT_W-1:0]  out_data
);

    localparam int D = clog2(N);

    logic [D-1:0] vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
        end else if (flush) begin
            vld <= '0;
        end else begin
            vld[0] <= in_valid;
            for (int i = 1; i < D; i++) vld[i] <= vld[i-1];
        end
    end

    for (genvar l = 0; l <= D; l++) begin : g_lvl
        localparam int CNT = (N + (1 << l) - 1) >> l;
        logic [OUT_W-1:0] s [CNT];
        if (l == 0) begin : g_in
            for (genvar j = 0; j < N; j++) begin : g_ext
                assign s[j] = OUT_W'($signed(in_data[(j+1)*IN_W-1 -: IN_W]));
            end
        end else begin : g_add
            localparam int PCNT = (N + (1 << (l - 1)) - 1) >> (l - 1);
            for (genvar j = 0; j < CNT; j++) begin : g_node
                if (2 * j + 1 < PCNT) begin : g_pair
                    always_ff @(posedge clk)
                        s[j] <= g_lvl[l-1].s[2*j] + g_lvl[l-1].s[2*j+1];
                end else begin : g_pass
                    always_ff @(posedge clk)
                        s[j] <= g_lvl[l-1].s[2*j];
                end
            end
        end
    end

    assign out_valid = vld[D-1];
    assign out_data  = g_lvl[D].s[0];

endmodule

// File: rtl/conv_mac_array.sv
// Signed K*K MAC over IN_CHANNELS beats, plus bias and output saturation.
// Define RELU_EN to force negative saturated results to zero.
module conv_mac_array
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int KERNEL_SIZE = 3,
    parameter int IN_CHANNELS = 4,
    parameter int ACC_WIDTH   = 24,
    parameter int OUT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   window_valid,
    input  logic [DATA_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] window_in,
    input  logic                   weight_valid,
    input  logic [DATA_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] weight_in,
    input  logic [OUT_WIDTH-1:0]   bias_in,
    output logic [OUT_WIDTH-1:0]   conv_out,
    output logic                   conv_valid,
    output logic                   sat_flag,
    output logic [((IN_CHANNELS > 1) ? clog2(IN_CHANNELS) : 1)-1:0] ch_idx
);

    localparam int K2 = KERNEL_SIZE * KERNEL_SIZE;
    localparam int D  = clog2(K2);
    localparam int CW = (IN_CHANNELS > 1) ? clog2(IN_CHANNELS) : 1;
    localparam int PW = 2 * DATA_WIDTH;
    localparam logic [CW-1:0] LAST = CW'(IN_CHANNELS - 1);

    function automatic logic [PW-1:0] mul(
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b
    );
        logic signed [PW-1:0] ax;
        logic signed [PW-1:0] bx;
        ax = PW'(a);
        bx = PW'(b);
        return ax * bx;
    endfunction

    logic accept;
    assign accept = window_valid && weight_valid && !clr;

    // Input capture stage
    logic                   in_v;
    logic [CW-1:0]          in_cnt;
    logic [DATA_WIDTH*K2-1:0] win_q;
    logic [DATA_WIDTH*K2-1:0] wgt_q;
    logic [OUT_WIDTH-1:0]   bias_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_v   <= 1'b0;
            in_cnt <= '0;
        end else if (clr) begin
            in_v   <= 1'b0;
            in_cnt <= '0;
        end else begin
            in_v <= accept;
            if (accept) in_cnt <= (in_cnt == LAST) ? '0 : in_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            win_q  <= window_in;
            wgt_q  <= weight_in;
            bias_q <= bias_in;
        end
    end

    assign ch_idx = in_cnt;

    // Stage M: parallel products
    logic               m_v;
    logic [PW*K2-1:0]   prod;
    logic [OUT_WIDTH-1:0] m_bias;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   m_v <= 1'b0;
        else if (clr) m_v <= 1'b0;
        else          m_v <= in_v;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < K2; i++)
            prod[i*PW +: PW] <= mul(win_q[i*DATA_WIDTH +: DATA_WIDTH],
                                    wgt_q[i*DATA_WIDTH +: DATA_WIDTH]);
        m_bias <= bias_q;
    end

    logic                        t_v;
    logic signed [ACC_WIDTH-1:0] t_sum;

    adder_tree_pipe #(
        .N     (K2),
        .IN_W  (PW),
        .OUT_W (ACC_WIDTH)
    ) u_tree (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (clr),
        .in_valid  (m_v),
        .in_data   (prod),
        .out_valid (t_v),
        .out_data  (t_sum)
    );

    // Bias rides alongside the tree levels
    logic [OUT_WIDTH-1:0] b_dly [1:D];

    always_ff @(posedge clk) begin
        b_dly[1] <= m_bias;
        for (int i = 2; i <= D; i++) b_dly[i] <= b_dly[i-1];
    end

    // Stage A: channel accumulation
    logic                        a_v;
    logic [CW-1:0]               acc_cnt;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] acc_sum;
    logic signed [ACC_WIDTH-1:0] fin;
    logic signed [OUT_WIDTH-1:0] a_bias;

    assign acc_sum = (acc_cnt == '0) ? t_sum : acc + t_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_v     <= 1'b0;
            acc_cnt <= '0;
        end else if (clr) begin
            a_v     <= 1'b0;
            acc_cnt <= '0;
        end else begin
            a_v <= t_v && (acc_cnt == LAST);
            if (t_v) acc_cnt <= (acc_cnt == LAST) ? '0 : acc_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (t_v) begin
            acc    <= acc_sum;
            fin    <= acc_sum;
            a_bias <= b_dly[D];
        end
    end

    // Stage O: bias, saturation, optional rectification
    logic signed [63:0]   o_sum;
    sat_t                 o_sat;
    logic [OUT_WIDTH-1:0] o_res;

    always_comb begin
        o_sum = 64'(fin) + 64'(a_bias);
        o_sat = saturate(o_sum, OUT_WIDTH);
        o_res = OUT_WIDTH'(o_sat.val);
`ifdef RELU_EN
        if ($signed(o_sat.val) < 0) o_res = '0;
`else
        o_res = OUT_WIDTH'(o_sat.val);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conv_valid <= 1'b0;
            conv_out   <= '0;
            sat_flag   <= 1'b0;
        end else if (clr || !a_v) begin
            conv_valid <= 1'b0;
            conv_out   <= '0;
            sat_flag   <= 1'b0;
        end else begin
            conv_valid <= 1'b1;
            conv_out   <= o_res;
            sat_flag   <= o_sat.flag;
        end
    end

endmodule

// File: tb/tb_conv_mac_array.sv
// Self-checking bench for conv_mac_array: vector table, corner sequences
// and randomized beats against a group-level arithmetic model.
module tb_conv_mac_array;

    localparam int DW  = 8;
    localparam int K2  = 9;
    localparam int IC  = 4;
    localparam int OW  = 16;
    localparam int LAT = 7;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            clr = 1'b0;
    logic            window_valid = 1'b0;
    logic            weight_valid = 1'b0;
    logic [DW*K2-1:0] window_in = '0;
    logic [DW*K2-1:0] weight_in = '0;
    logic [OW-1:0]   bias_in = '0;
    logic [OW-1:0]   conv_out;
    logic            conv_valid;
    logic            sat_flag;
    logic [1:0]      ch_idx;

    always #5 clk = ~clk;

    conv_mac_array dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .window_valid (window_valid),
        .window_in    (window_in),
        .weight_valid (weight_valid),
        .weight_in    (weight_in),
        .bias_in      (bias_in),
        .conv_out     (conv_out),
        .conv_valid   (conv_valid),
        .sat_flag     (sat_flag),
        .ch_idx       (ch_idx)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic void clip(input longint s, output int v, output bit f);
        f = 1'b0;
        v = int'(s);
        if (s > 32767) begin
            v = 32767;
            f = 1'b1;
        end else if (s < -32768) begin
            v = -32768;
            f = 1'b1;
        end
`ifdef RELU_EN
        if (v < 0) v = 0;
`endif
    endfunction

    // Group-level scoreboard
    typedef struct {
        int due;
        int val;
        bit sat;
    } exp_t;

    exp_t   expq[$];
    int     cyc = 0;
    int     mcnt = 0;
    longint macc = 0;
    int     res_cnt = 0;
    int     res_val[$];
    int     res_cyc[$];
    int     last_val = 0;
    int     last_sat = 0;
    int     last_cyc = 0;
    int     grp_cyc = 0;
    int     mv;
    bit     mf;
    exp_t   e;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (!rst_n) begin
            expq.delete();
            mcnt = 0;
            macc = 0;
            check("rst_valid", conv_valid, 0);
            check("rst_out", conv_out, 0);
            check("rst_sat", sat_flag, 0);
            check("rst_idx", ch_idx, 0);
        end else begin
            if (clr) begin
                while (expq.size() > 0 && expq[$].due >= cyc)
                    void'(expq.pop_back());
                mcnt = 0;
                macc = 0;
            end else if (window_valid && weight_valid) begin
                for (int k = 0; k < K2; k++) begin
                    int a;
                    int b;
                    a = $signed(window_in[k*DW +: DW]);
                    b = $signed(weight_in[k*DW +: DW]);
                    macc += longint'(a * b);
                end
                mcnt++;
                if (mcnt == IC) begin
                    clip(macc + longint'($signed(bias_in)), mv, mf);
                    expq.push_back('{cyc + LAT, mv, mf});
                    grp_cyc = cyc;
                    mcnt = 0;
                    macc = 0;
                end
            end
            if (conv_valid) begin
                res_cnt++;
                last_val = $signed(conv_out);
                last_sat = sat_flag;
                last_cyc = cyc;
                res_val.push_back(last_val);
                res_cyc.push_back(cyc);
            end
            if (expq.size() > 0 && expq[0].due == cyc) begin
                e = expq.pop_front();
                check("res_valid", conv_valid, 1);
                check("res_out", $signed(conv_out), e.val);
                check("res_sat", sat_flag, e.sat);
            end else begin
                check("idle_valid", conv_valid, 0);
                check("idle_out", conv_out, 0);
                check("idle_sat", sat_flag, 0);
            end
            check("ch_idx", ch_idx, mcnt);
        end
    end

    task automatic drive(input logic [DW*K2-1:0] w, input logic [DW*K2-1:0] g,
                         input int b, input bit v, input bit c);
        @(negedge clk);
        window_in    = w;
        weight_in    = g;
        bias_in      = OW'(b);
        window_valid = v;
        weight_valid = v;
        clr          = c;
    endtask

    task automatic idle(input int n);
        repeat (n) drive('0, '0, 0, 1'b0, 1'b0);
    endtask

    function automatic logic [DW*K2-1:0] fill(input int v);
        logic [DW*K2-1:0] r;
        for (int k = 0; k < K2; k++) r[k*DW +: DW] = DW'(v);
        return r;
    endfunction

    function automatic logic [DW*K2-1:0] rnd();
        logic [DW*K2-1:0] r;
        for (int k = 0; k < K2; k++) r[k*DW +: DW] = DW'($urandom);
        return r;
    endfunction

    task automatic group(input int w, input int g, input int bias, input bit gaps);
        for (int b = 0; b < IC; b++) begin
            drive(fill(w), fill(g), (b == IC - 1) ? bias : int'($urandom), 1'b1, 1'b0);
            if (gaps) idle($urandom_range(0, 3));
        end
    endtask

    typedef struct {
        int w;
        int g;
        int bias;
        int exp_out;
        bit exp_sat;
    } vec_t;

    vec_t vt[8];
    int   base;
    int   n;
    int   b2b_val[3];
    int   b2b_cyc[3];

    initial begin
`ifdef RELU_EN
        vt[0] = '{1, 1, 0, 36, 0};
        vt[1] = '{2, 3, -16, 200, 0};
        vt[2] = '{-128, -128, 0, 32767, 1};
        vt[3] = '{-128, 127, 0, 0, 1};
        vt[4] = '{5, -7, 100, 0, 0};
        vt[5] = '{0, 0, -32768, 0, 0};
        vt[6] = '{127, 127, -5, 32767, 1};
        vt[7] = '{1, -1, -32768, 0, 1};
`else
        vt[0] = '{1, 1, 0, 36, 0};
        vt[1] = '{2, 3, -16, 200, 0};
        vt[2] = '{-128, -128, 0, 32767, 1};
        vt[3] = '{-128, 127, 0, -32768, 1};
        vt[4] = '{5, -7, 100, -1160, 0};
        vt[5] = '{0, 0, -32768, -32768, 0};
        vt[6] = '{127, 127, -5, 32767, 1};
        vt[7] = '{1, -1, -32768, -32768, 1};
`endif
        idle(3);
        @(negedge clk) rst_n = 1'b1;
        idle(2);

        for (int i = 0; i < 8; i++) begin
            base = res_cnt;
            group(vt[i].w, vt[i].g, vt[i].bias, 1'b0);
            idle(10);
            check("tbl_count", res_cnt - base, 1);
            check("tbl_out", last_val, vt[i].exp_out);
            check("tbl_sat", last_sat, vt[i].exp_sat);
            check("tbl_latency", last_cyc - grp_cyc, LAT);
        end

        // Abort a partial group, then a full group
        base = res_cnt;
        drive(fill(1), fill(1), 0, 1'b1, 1'b0);
        drive(fill(1), fill(1), 0, 1'b1, 1'b0);
        drive('0, '0, 0, 1'b0, 1'b1);
        group(1, 1, 0, 1'b0);
        idle(10);
        check("clr_count", res_cnt - base, 1);
        check("clr_out", last_val, 36);

        // Beat coincident with clr is dropped
        drive(fill(1), fill(1), 0, 1'b1, 1'b1);
        idle(1);
        check("clr_beat_idx", ch_idx, 0);

        // Back-to-back groups, then the same with gaps
        base = res_cnt;
        for (int g = 1; g <= 3; g++) group(g, 1, 0, 1'b0);
        idle(10);
        n = res_val.size();
        check("b2b_count", res_cnt - base, 3);
        if (n >= 3) begin
            for (int k = 0; k < 3; k++) begin
                b2b_val[k] = res_val[n-3+k];
                b2b_cyc[k] = res_cyc[n-3+k];
                check("b2b_out", b2b_val[k], 36 * (k + 1));
            end
            check("b2b_spacing1", b2b_cyc[1] - b2b_cyc[0], IC);
            check("b2b_spacing2", b2b_cyc[2] - b2b_cyc[1], IC);
        end
        base = res_cnt;
        for (int g = 1; g <= 3; g++) group(g, 1, 0, 1'b1);
        idle(10);
        n = res_val.size();
        check("gap_count", res_cnt - base, 3);
        if (n >= 3)
            for (int k = 0; k < 3; k++)
                check("gap_vs_b2b", res_val[n-3+k], b2b_val[k]);

        // Reset in the middle of a group
        base = res_cnt;
        for (int b = 0; b < 3; b++) drive(fill(1), fill(1), 0, 1'b1, 1'b0);
        @(negedge clk) rst_n = 1'b0;
        idle(2);
        @(negedge clk) rst_n = 1'b1;
        group(1, 1, 0, 1'b0);
        idle(10);
        check("rst_count", res_cnt - base, 1);
        check("rst_out", last_val, 36);

        // Randomized beats, gaps, partial valids and aborts
        for (int i = 0; i < 200; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 5) begin
                drive(rnd(), rnd(), int'($urandom), 1'b1, 1'b1);
            end else if (r < 10) begin
                drive(rnd(), rnd(), int'($urandom), 1'b0, 1'b0);
                window_valid = $urandom_range(0, 1);
                weight_valid = !window_valid;
            end else if (r < 30) begin
                idle(1);
            end else begin
                drive(rnd(), rnd(), int'($urandom), 1'b1, 1'b0);
            end
        end
        idle(12);
        check("drain", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_mac_array.md
# conv_mac_array

Parametrised signed multiply-accumulate engine for the convolution datapath. It sits between the line-buffer window generator and the output feature-map writer. Each accepted beat computes a KERNEL_SIZE×KERNEL_SIZE dot product through a pipelined binary adder tree, then accumulates IN_CHANNELS consecutive beats into one output pixel. The block adds a per-output bias and saturates to OUT_WIDTH with an overflow flag.

## Interface
- DATA_WIDTH, 8: signed width of each window and weight element
- KERNEL_SIZE, 3: kernel edge; K2 = KERNEL_SIZE*KERNEL_SIZE elements per beat
- IN_CHANNELS, 4: beats accumulated per output pixel (≥1)
- ACC_WIDTH, 24: internal signed accumulator width; must be ≥ 2*DATA_WIDTH + clog2(K2*IN_CHANNELS) + 1
- OUT_WIDTH, 16: signed output width
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  synchronous abort: discards the partial accumulation and flushes in-flight beats
- window_valid  in  1  window data valid
- window_in  in  DATA_WIDTH*K2  packed window; element i sits at [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH]
- weight_valid  in  1  weight data valid
- weight_in  in  DATA_WIDTH*K2  packed weights, same packing as window_in
- bias_in  in  OUT_WIDTH  signed bias, sampled with the last beat of a group
- conv_out  out  OUT_WIDTH  signed result, 0 when conv_valid is low
- conv_valid  out  1  one-cycle result strobe
- sat_flag  out  1  result was clipped; qualified by conv_valid, 0 otherwise
- ch_idx  out  clog2(IN_CHANNELS) (min 1)  index of the next beat to be accepted

## Operation
- Beat accepted ⇔ window_valid && weight_valid && !clr. There is no backpressure, and gaps between beats are allowed.
- Stage M: K2 parallel signed products (2*DATA_WIDTH bits), registered.
- Tree: D = clog2(K2) registered levels. Each level pairs adjacent terms; an odd leftover passes through registered. Operands are sign-extended to ACC_WIDTH at level 1.
- Stage A, accumulator:
  - ch_cnt == 0: acc <= tree_sum
  - otherwise: acc <= acc + tree_sum
  - ch_cnt wraps from IN_CHANNELS-1 to 0.
  - The last beat forwards acc+tree_sum and the bias captured with that beat to stage O.
- Stage O: sum = final + sign_ext(bias). The result saturates to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1], and sat_flag is set when clipped.
- ch_idx reflects the input-side beat count, so it updates on acceptance.
- clr:
  - Zeroes the valid bits of all stages and both counters. Data registers need not clear.
  - No conv_valid is produced for the aborted group.
  - clr with a valid beat in the same cycle: clr wins and the beat is discarded.
- IN_CHANNELS = 1: every beat produces a result.
- Reset: all valid bits 0, counters 0, conv_out 0, conv_valid 0, sat_flag 0, ch_idx 0. Reset mid-group drops the group.

## Timing
- Latency: conv_valid asserts D+3 cycles after the clock edge that accepts the group's last beat. K=3 gives D=4, so latency is 7.
- Fully pipelined: back-to-back groups give one result every IN_CHANNELS cycles.
- Valid bits travel with data, and bias is pipelined alongside them.
- Stage O output is registered. conv_out/sat_flag change only on conv_valid cycles and return to 0 the next cycle when no result follows.

## Configuration
- RELU_EN defined: after saturation, negative results are forced to 0. sat_flag still reports any saturation that occurred.
- RELU_EN undefined: signed result is passed through unchanged.

## Structure
- Shared package conv_pkg holds:
  - the clog2 helper
  - the ACC_WIDTH minimum-width function
  - the signed saturate(value, OUT_WIDTH) function, returning result and flag
- Sub-module adder_tree_pipe (N inputs, IN_W, OUT_W) implements the D-level registered tree with a valid pipeline. It is reusable by pooling/FC blocks.

## Test plan
- Defaults, 4 beats with all windows 1, weights 1, bias 0 → conv_out 36, sat_flag 0, one pulse 7 cycles after the last beat.
- Windows 2, weights 3, bias -16 at the last beat → 4×54-16 = 200.
- Windows -128, weights -128 (sum 589824) → conv_out 32767, sat_flag 1. Windows -128, weights 127 → -32768, sat_flag 1; with RELU_EN → 0, sat_flag 1.
- 2 beats of ones, clr, then 4 beats of ones → exactly one result, 36. clr with a simultaneous beat → that beat not counted (ch_idx stays 0).
- 12 back-to-back beats (value pattern 1,2,3 per group) vs the same beats with random gaps → identical 3 results. Back-to-back results arrive 4 cycles apart.
- rst_n asserted after 3 beats, then released and 4 fresh beats → all outputs 0 during reset, single correct result, no stale partial sum.
